// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI receive path: receiver state
// encoding, status-byte classes and the channel-message length rule.
package midi_pkg;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_PROG     = 4'hC;
  localparam logic [3:0] ST_CHPRESS  = 4'hD;
  localparam logic [7:0] RT_MIN      = 8'hF8;
  localparam logic [7:0] SYS_MIN     = 8'hF0;

  // Program change and channel pressure carry one data byte, every other
  // channel message carries two.
  function automatic logic [1:0] data_len(input logic [7:0] status);
    if (status[7:4] == ST_PROG || status[7:4] == ST_CHPRESS) begin
      return 2'd1;
    end
    return 2'd2;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: two-flop synchronizer, mid-bit sampling from a
// down-counter, framing-error detection and break suppression.
module uart_byte_rx
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 31_250
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rx_in,
  output logic [7:0] byte_out,
  output logic       byte_valid_out,
  output logic       frame_err_out,
  output rx_state_t  state_out
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);

  localparam logic [2:0] S_IDLE      = RX_IDLE;
  localparam logic [2:0] S_START     = RX_START;
  localparam logic [2:0] S_DATA      = RX_DATA;
  localparam logic [2:0] S_STOP      = RX_STOP;
  localparam logic [2:0] S_WAIT_HIGH = RX_WAIT_HIGH;

  logic          sync1;
  logic          sync2;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick;

  assign tick      = (cnt == '0);
  assign state_out = rx_state_t'(state);

  // Synchronizer resets to the idle line level so reset never fakes a start.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= S_IDLE;
      cnt            <= '0;
      bit_idx        <= 3'd0;
      shreg          <= 8'h00;
      byte_out       <= 8'h00;
      byte_valid_out <= 1'b0;
      frame_err_out  <= 1'b0;
    end else begin
      byte_valid_out <= 1'b0;
      frame_err_out  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!sync2) begin
            cnt   <= HALF_M1;
            state <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (!sync2) begin
              cnt     <= FULL_M1;
              bit_idx <= 3'd0;
              state   <= S_DATA;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (tick) begin
            shreg <= {sync2, shreg[7:1]};
            cnt   <= FULL_M1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (sync2) begin
              byte_out       <= shreg;
              byte_valid_out <= 1'b1;
              state          <= S_IDLE;
            end else begin
              frame_err_out <= 1'b1;
              state         <= S_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          // A held break stays here, so it reports one error, not many.
          if (sync2) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/midi_rx.sv
// MIDI input: byte receiver plus a channel-message parser with running
// status and real-time bytes passed through between data bytes.
module midi_rx
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 31_250
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rx_in,
  output logic [7:0] byte_out,
  output logic       byte_valid_out,
  output logic       frame_err_out,
  output logic       msg_valid_out,
  output logic [7:0] msg_status_out,
  output logic [6:0] msg_data1_out,
  output logic [6:0] msg_data2_out,
  output logic       busy_out
);

  // All *_valid_out / *_err_out outputs are single-cycle pulses with no
  // ready: a consumer must take the qualified data on the pulse cycle.
  // byte_out and the msg_* fields hold until the next pulse replaces them.

  rx_state_t  rx_state;
  logic [7:0] run_status;
  logic       run_valid;
  logic       data_cnt;
  logic [6:0] held_d1;

  uart_byte_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rx_in          (rx_in),
    .byte_out       (byte_out),
    .byte_valid_out (byte_valid_out),
    .frame_err_out  (frame_err_out),
    .state_out      (rx_state)
  );

  assign busy_out = (rx_state != RX_IDLE);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      msg_valid_out  <= 1'b0;
      msg_status_out <= 8'h00;
      msg_data1_out  <= 7'h00;
      msg_data2_out  <= 7'h00;
      run_status     <= 8'h00;
      run_valid      <= 1'b0;
      data_cnt       <= 1'b0;
      held_d1        <= 7'h00;
    end else begin
      msg_valid_out <= 1'b0;
      if (byte_valid_out) begin
        if (byte_out >= RT_MIN) begin
          // Real-time bytes leave running status and partial data intact.
          msg_valid_out  <= 1'b1;
          msg_status_out <= byte_out;
          msg_data1_out  <= 7'h00;
          msg_data2_out  <= 7'h00;
        end else if (byte_out >= SYS_MIN) begin
          run_status <= 8'h00;
          run_valid  <= 1'b0;
          data_cnt   <= 1'b0;
        end else if (byte_out[7]) begin
          run_status <= byte_out;
          run_valid  <= 1'b1;
          data_cnt   <= 1'b0;
        end else if (run_valid) begin
          if (data_len(run_status) == 2'd1) begin
            msg_valid_out  <= 1'b1;
            msg_status_out <= run_status;
            msg_data1_out  <= byte_out[6:0];
            msg_data2_out  <= 7'h00;
          end else if (!data_cnt) begin
            held_d1  <= byte_out[6:0];
            data_cnt <= 1'b1;
          end else begin
            msg_valid_out  <= 1'b1;
            msg_status_out <= run_status;
            msg_data1_out  <= held_d1;
            msg_data2_out  <= byte_out[6:0];
            data_cnt       <= 1'b0;
          end
        end
      end
    end
  end

endmodule
